// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN sequencer and IF/ID pipeline register.
// Optional FETCH_MISALIGN_TRAP_EN adds a registered MisalignD flag for non-word-aligned PCD.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        MisalignD,
`endif
    output logic        ValidD
);

    localparam int unsigned XLEN = 32;

    localparam logic [0:0] BOOT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]      state;
    logic [0:0]      state_nxt;
    logic [XLEN-1:0] pc_plus4_f;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] instr_d_nxt;
    logic [XLEN-1:0] pc_d_nxt;
    logic [XLEN-1:0] pc_plus4_d_nxt;
    logic            valid_d_nxt;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misalign_d_nxt;
`endif

    // Sequential fetch wraps naturally at 2^32.
    assign pc_plus4_f = PCF + XLEN'(4);

    // State, PC and IF/ID register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            PCF      <= RESET_PC;
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            MisalignD <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            PCF      <= pc_nxt;
            InstrD   <= instr_d_nxt;
            PCD      <= pc_d_nxt;
            PCPlus4D <= pc_plus4_d_nxt;
            ValidD   <= valid_d_nxt;
`ifdef FETCH_MISALIGN_TRAP_EN
            MisalignD <= misalign_d_nxt;
`endif
        end
    end

    // Next-state, next-PC and IF/ID load selection; hold is the default.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = PCF;
        instr_d_nxt    = InstrD;
        pc_d_nxt       = PCD;
        pc_plus4_d_nxt = PCPlus4D;
        valid_d_nxt    = ValidD;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d_nxt = MisalignD;
`endif
        case (state)
            BOOT: begin
                state_nxt      = RUN;
                pc_nxt         = RESET_PC;
                instr_d_nxt    = NOP_INSTR;
                pc_d_nxt       = '0;
                pc_plus4_d_nxt = '0;
                valid_d_nxt    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                misalign_d_nxt = 1'b0;
`endif
            end
            RUN: begin
                // A redirect must not be lost to a concurrent fetch stall.
                if (PCSrcE) begin
                    pc_nxt = PCTargetE;
                end else if (!StallF) begin
                    pc_nxt = pc_plus4_f;
                end

                // Flush beats stall so a squashed slot never lingers.
                if (FlushD) begin
                    instr_d_nxt    = NOP_INSTR;
                    pc_d_nxt       = '0;
                    pc_plus4_d_nxt = '0;
                    valid_d_nxt    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                    misalign_d_nxt = 1'b0;
`endif
                end else if (!StallD) begin
                    instr_d_nxt    = InstrF;
                    pc_d_nxt       = PCF;
                    pc_plus4_d_nxt = pc_plus4_f;
                    valid_d_nxt    = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                    misalign_d_nxt = (PCF[1:0] != 2'b00);
`endif
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed self-checking bench for instruction_fetch_stage (default and wrap-around RESET_PC instances).
module tb_instruction_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrF;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        MisalignD;
    logic        w_MisalignD;
`endif

    logic [31:0] w_PCF, w_InstrD, w_PCD, w_PCPlus4D;
    logic        w_ValidD;

    int checks = 0;
    int errors = 0;

    instruction_fetch_stage u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .InstrF    (InstrF),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
`ifdef FETCH_MISALIGN_TRAP_EN
        .MisalignD (MisalignD),
`endif
        .ValidD    (ValidD)
    );

    instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk       (clk),
        .rst_n     (rst_n),
        .StallF    (1'b0),
        .StallD    (1'b0),
        .FlushD    (1'b0),
        .PCSrcE    (1'b0),
        .PCTargetE (32'h0),
        .InstrF    (32'h0000_1234),
        .PCF       (w_PCF),
        .InstrD    (w_InstrD),
        .PCD       (w_PCD),
        .PCPlus4D  (w_PCPlus4D),
`ifdef FETCH_MISALIGN_TRAP_EN
        .MisalignD (w_MisalignD),
`endif
        .ValidD    (w_ValidD)
    );

    // Instruction memory model: each word is tagged with its own address.
    assign InstrF = 32'hA000_0000 ^ PCF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_d(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] pc4, input logic valid);
        chk({tag, "_instr"}, InstrD, instr);
        chk({tag, "_pcd"}, PCD, pc);
        chk({tag, "_pc4d"}, PCPlus4D, pc4);
        chk({tag, "_valid"}, 32'(ValidD), 32'(valid));
    endtask

    initial begin
        rst_n = 1'b0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = 32'h0;
        #12;
        chk("rst_pcf", PCF, 32'h0);
        chk_d("rst", 32'h0000_0013, 32'h0, 32'h0, 1'b0);
        chk("wrap_rst_pcf", w_PCF, 32'hFFFF_FFFC);

        // BOOT ignores every control input.
        rst_n = 1'b1;
        PCSrcE = 1'b1; PCTargetE = 32'h40; StallF = 1'b1; StallD = 1'b1;
        step();
        chk("boot_pcf", PCF, 32'h0);
        chk_d("boot", 32'h0000_0013, 32'h0, 32'h0, 1'b0);
        chk("wrap_boot_pcf", w_PCF, 32'hFFFF_FFFC);
        PCSrcE = 1'b0; StallF = 1'b0; StallD = 1'b0; PCTargetE = 32'h0;

        step();
        chk("run1_pcf", PCF, 32'h4);
        chk_d("run1", 32'hA000_0000, 32'h0, 32'h4, 1'b1);
        chk("wrap_run1_pcf", w_PCF, 32'h0);
        chk("wrap_run1_pcd", w_PCD, 32'hFFFF_FFFC);
        chk("wrap_run1_pc4d", w_PCPlus4D, 32'h0);

        step();
        chk("run2_pcf", PCF, 32'h8);
        chk_d("run2", 32'hA000_0004, 32'h4, 32'h8, 1'b1);
        chk("wrap_run2_pcf", w_PCF, 32'h4);

        // Redirect with simultaneous fetch stall; no implicit flush of D.
        PCSrcE = 1'b1; PCTargetE = 32'h24; StallF = 1'b1;
        step();
        chk("redir_pcf", PCF, 32'h24);
        chk_d("redir", 32'hA000_0008, 32'h8, 32'hC, 1'b1);

        // Redirect back to 12 to walk toward PCF=16.
        StallF = 1'b0; PCTargetE = 32'hC;
        step();
        chk("redir2_pcf", PCF, 32'hC);
        chk_d("redir2", 32'hA000_0024, 32'h24, 32'h28, 1'b1);
        PCSrcE = 1'b0; PCTargetE = 32'h0;

        step();
        chk("seq16_pcf", PCF, 32'h10);
        chk_d("seq16", 32'hA000_000C, 32'hC, 32'h10, 1'b1);

        // Full stall holds a valid D entry.
        StallF = 1'b1; StallD = 1'b1;
        step();
        chk("hold_pcf", PCF, 32'h10);
        chk_d("hold", 32'hA000_000C, 32'hC, 32'h10, 1'b1);

        // Flush beats stall on the IF/ID register.
        FlushD = 1'b1;
        step();
        chk("flstall_pcf", PCF, 32'h10);
        chk_d("flstall", 32'h0000_0013, 32'h0, 32'h0, 1'b0);
        FlushD = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall3_pcf", PCF, 32'h10);
            chk_d("stall3", 32'h0000_0013, 32'h0, 32'h0, 1'b0);
        end
        StallF = 1'b0; StallD = 1'b0;

        step();
        chk("resume_pcf", PCF, 32'h14);
        chk_d("resume", 32'hA000_0010, 32'h10, 32'h14, 1'b1);

        // Decode-only stall: fetch advances, D holds.
        StallD = 1'b1;
        step();
        chk("stalld_pcf", PCF, 32'h18);
        chk_d("stalld", 32'hA000_0010, 32'h10, 32'h14, 1'b1);
        StallD = 1'b0;

        FlushD = 1'b1;
        step();
        chk("flush_pcf", PCF, 32'h1C);
        chk_d("flush", 32'h0000_0013, 32'h0, 32'h0, 1'b0);
        FlushD = 1'b0;

        // Misaligned redirect target.
        PCSrcE = 1'b1; PCTargetE = 32'h22;
        step();
        chk("mis_pcf", PCF, 32'h22);
        chk_d("mis_pre", 32'hA000_001C, 32'h1C, 32'h20, 1'b1);
        PCSrcE = 1'b0; PCTargetE = 32'h0;

        step();
        chk("mis_next_pcf", PCF, 32'h26);
        chk_d("mis", 32'hA000_0022, 32'h22, 32'h26, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_flag", 32'(MisalignD), 32'h1);
`endif

        // Asynchronous reset mid-cycle with stall/flush/redirect active.
        StallF = 1'b1; StallD = 1'b1; FlushD = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h80;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_pcf", PCF, 32'h0);
        chk_d("arst", 32'h0000_0013, 32'h0, 32'h0, 1'b0);
        chk("wrap_arst_pcf", w_PCF, 32'hFFFF_FFFC);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("arst_mis", 32'(MisalignD), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
